multicycle_ctrl: RTL and testbench

Parametrised multicycle control unit for the 16-bit baby-CPU datapath: sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK per instruction and drives every datapath select/enable line. It generalises the four-state controller with memory ready/wait handshaking on fetch and load/store, a dedicated MEM state, and an optional conditional branch/jump path. It sits between the instruction register/flag register and the PC, register file, ALU muxes and memory port.

---
 rtl/multicycle_ctrl_pkg.sv | 56 +++++
 rtl/multicycle_ctrl_if.sv | 36 +++
 rtl/multicycle_ctrl_cond_eval.sv | 31 +++
 rtl/multicycle_ctrl.sv | 150 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and encodings for the multicycle baby-CPU controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state enum, major opcodes, ext codes, immTypeSel/wbSel encodings,
// branch condition codes and flag bit positions within {Z,C,N,F,L}.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4
  } state_e;

  // Major opcodes (instruction[15:12])
  localparam logic [3:0] OPC_RTYPE = 4'b0000;
  localparam logic [3:0] OPC_ANDI  = 4'b0001;
  localparam logic [3:0] OPC_ORI   = 4'b0010;
  localparam logic [3:0] OPC_LDST  = 4'b0100;
  localparam logic [3:0] OPC_ADDI  = 4'b0101;
  localparam logic [3:0] OPC_BCOND = 4'b1100;
  localparam logic [3:0] OPC_MOVI  = 4'b1101;
  localparam logic [3:0] OPC_LUI   = 4'b1111;

  // Ext codes within the load/store/jump group (instruction[7:4])
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STORE = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  // Immediate formatter select
  localparam logic [1:0] IMM_LUI  = 2'b00;
  localparam logic [1:0] IMM_SEXT = 2'b01;
  localparam logic [1:0] IMM_ZEXT = 2'b10;

  // Register-file write-back source
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_LINK = 2'b10;

  // Branch condition codes (instruction[11:8])
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_GT = 4'b0110;
  localparam logic [3:0] COND_LE = 4'b0111;
  localparam logic [3:0] COND_UC = 4'b1110;

  // Bit positions inside flags = {Z,C,N,F,L}
  localparam int FLAG_Z = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Bundle between the controller and the baby-CPU datapath/memory port.
// Latency: n/a (wires only).
// Backpressure: memReady from memory stalls the controller in FETCH/MEM.
// Modports: master = controller (drives select/enable lines, reads IR/flags/memReady),
//           slave  = datapath/memory side.
interface multicycle_ctrl_if #(
  parameter int INSTR_W = 16
);
  logic [INSTR_W-1:0] instruction;
  logic [4:0]         flags;
  logic               memReady;

  logic               pcEn;
  logic               pcIncOrSet;
  logic               irEn;
  logic               rfWe;
  logic               pcRegSel;
  logic               r2ImSel;
  logic [1:0]         immTypeSel;
  logic               memReq;
  logic               memWe;
  logic [1:0]         wbSel;
  logic [2:0]         state;

  modport master (
    input  instruction, flags, memReady,
    output pcEn, pcIncOrSet, irEn, rfWe, pcRegSel, r2ImSel,
           immTypeSel, memReq, memWe, wbSel, state
  );

  modport slave (
    output instruction, flags, memReady,
    input  pcEn, pcIncOrSet, irEn, rfWe, pcRegSel, r2ImSel,
           immTypeSel, memReq, memWe, wbSel, state
  );
endinterface

// File: rtl/multicycle_ctrl_cond_eval.sv
// Branch condition evaluator: decides taken/not-taken from cond and {Z,C,N,F,L}.
// Latency: combinational.
// Backpressure: none.
// Ports: cond (4b condition code), flags (5b), taken (1b). Unlisted codes never take.
module cond_eval
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       taken
);

  // F and L take no part in any condition.
  logic unused_fl;
  assign unused_fl = ^flags[1:0];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = flags[FLAG_Z];
      COND_NE: taken = ~flags[FLAG_Z];
      COND_CS: taken = flags[FLAG_C];
      COND_CC: taken = ~flags[FLAG_C];
      COND_GT: taken = flags[FLAG_N];
      COND_LE: taken = ~flags[FLAG_N];
      COND_UC: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle controller: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencing for the baby CPU.
// Latency: 4 cycles per instruction, 5 for LOAD/STORE, +1 per memReady=0 cycle in FETCH/MEM.
// Backpressure: holds FETCH or MEM (memReq kept high) while memReady is low.
// Ports: clock, reset (async, active-high); bus (multicycle_ctrl_if.master) carries
//   instruction/flags/memReady in and every datapath select/enable plus debug state out.
// Optional: define CTRL_BRANCH_EN to decode Bcond, Jcond and JAL; otherwise those are NOPs.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int         INSTR_W   = 16,
  parameter logic [3:0] LDST_OPC  = 4'b0100,
  parameter logic [3:0] LOAD_EXT  = 4'b0000,
  parameter logic [3:0] STORE_EXT = 4'b0100
) (
  input logic              clock,
  input logic              reset,
  multicycle_ctrl_if.master bus
);

  state_e state_q, state_d;

  // Instruction fields; IR is guaranteed stable from DECODE through WRITEBACK.
  logic [3:0] opcode;
  logic [3:0] ext;
  assign opcode = bus.instruction[INSTR_W-1 -: 4];
  assign ext    = bus.instruction[7:4];

  logic is_ldst, is_load, is_store, is_alu;
  logic is_bcond, is_jcond, is_jal, cond_taken;

  assign is_ldst  = (opcode == LDST_OPC);
  assign is_load  = is_ldst && (ext == LOAD_EXT);
  assign is_store = is_ldst && (ext == STORE_EXT);
  assign is_alu   = (opcode == OPC_RTYPE) || (opcode == OPC_ANDI) || (opcode == OPC_ORI) ||
                    (opcode == OPC_ADDI)  || (opcode == OPC_MOVI) || (opcode == OPC_LUI);

`ifdef CTRL_BRANCH_EN
  logic [3:0] cond;
  assign cond     = bus.instruction[11:8];
  assign is_bcond = (opcode == OPC_BCOND);
  assign is_jcond = is_ldst && (ext == EXT_JCOND);
  assign is_jal   = is_ldst && (ext == EXT_JAL);

  cond_eval u_cond_eval (
    .cond  (cond),
    .flags (bus.flags),
    .taken (cond_taken)
  );
`else
  assign is_bcond   = 1'b0;
  assign is_jcond   = 1'b0;
  assign is_jal     = 1'b0;
  assign cond_taken = 1'b0;
`endif

  logic       pc_en, pc_inc_or_set, ir_en, rf_we, pc_reg_sel, r2_im_sel;
  logic [1:0] imm_type_sel, wb_sel;
  logic       mem_req, mem_we;

  always_comb begin
    state_d       = state_q;
    pc_en         = 1'b0;
    pc_inc_or_set = 1'b0;
    ir_en         = 1'b0;
    rf_we         = 1'b0;
    pc_reg_sel    = 1'b1;
    r2_im_sel     = 1'b0;
    imm_type_sel  = IMM_LUI;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    wb_sel        = WB_ALU;

    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        // reset is async: memReady seen while it is held must not load the IR.
        if (bus.memReady && !reset) begin
          ir_en   = 1'b1;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: state_d = ST_EXECUTE;

      ST_EXECUTE: begin
        case (opcode)
          OPC_ANDI, OPC_ORI, OPC_MOVI: begin
            r2_im_sel    = 1'b1;
            imm_type_sel = IMM_ZEXT;
          end
          OPC_ADDI: begin
            r2_im_sel    = 1'b1;
            imm_type_sel = IMM_SEXT;
          end
          OPC_LUI: begin
            r2_im_sel    = 1'b1;
            imm_type_sel = IMM_LUI;
          end
          default: ;
        endcase
        // Bcond: ALU computes PC + sext(disp) for the target.
        if (is_bcond) begin
          pc_reg_sel   = 1'b0;
          r2_im_sel    = 1'b1;
          imm_type_sel = IMM_SEXT;
        end
        state_d = (is_load || is_store) ? ST_MEM : ST_WRITEBACK;
      end

      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        if (bus.memReady) state_d = ST_WRITEBACK;
      end

      ST_WRITEBACK: begin
        pc_en = 1'b1;
        rf_we = is_alu || is_load || is_jal;
        if (is_load) wb_sel = WB_MEM;
        if (is_jal) begin
          wb_sel        = WB_LINK;
          pc_inc_or_set = 1'b1;
        end
        if (is_bcond || is_jcond) pc_inc_or_set = cond_taken;
        state_d = ST_FETCH;
      end

      // Encodings 5..7 recover to FETCH with default outputs.
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  assign bus.pcEn       = pc_en;
  assign bus.pcIncOrSet = pc_inc_or_set;
  assign bus.irEn       = ir_en;
  assign bus.rfWe       = rf_we;
  assign bus.pcRegSel   = pc_reg_sel;
  assign bus.r2ImSel    = r2_im_sel;
  assign bus.immTypeSel = imm_type_sel;
  assign bus.memReq     = mem_req;
  assign bus.memWe      = mem_we;
  assign bus.wbSel      = wb_sel;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus random instruction stream.
// Expected per-cycle outputs come from an instruction-class trace model.
// Honors CTRL_BRANCH_EN the same way as the design.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  typedef struct packed {
    logic       pc_en;
    logic       pc_inc;
    logic       ir_en;
    logic       rf_we;
    logic       pc_reg_sel;
    logic       r2_im_sel;
    logic [1:0] imm;
    logic       mem_req;
    logic       mem_we;
    logic [1:0] wb;
    logic [2:0] st;
  } obs_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  multicycle_ctrl_if #(.INSTR_W(16)) bus ();

  multicycle_ctrl #(
    .INSTR_W   (16),
    .LDST_OPC  (4'b0100),
    .LOAD_EXT  (4'b0000),
    .STORE_EXT (4'b0100)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  obs_t exp_q[$];
  obs_t got_q[$];
  logic rdy_q[$];

  function automatic obs_t sample();
    obs_t o;
    o.pc_en      = bus.pcEn;
    o.pc_inc     = bus.pcIncOrSet;
    o.ir_en      = bus.irEn;
    o.rf_we      = bus.rfWe;
    o.pc_reg_sel = bus.pcRegSel;
    o.r2_im_sel  = bus.r2ImSel;
    o.imm        = bus.immTypeSel;
    o.mem_req    = bus.memReq;
    o.mem_we     = bus.memWe;
    o.wb         = bus.wbSel;
    o.st         = bus.state;
    return o;
  endfunction

  // Branch condition table over {Z,C,N,F,L}.
  function automatic logic cond_model(input logic [3:0] c, input logic [4:0] f);
    logic z, cy, n;
    z = f[4]; cy = f[3]; n = f[2];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd6:  return n;
      4'd7:  return !n;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Builds the expected output trace of one instruction, with fw fetch waits
  // and mw data waits, plus the memReady value to drive each cycle.
  task automatic build_trace(input logic [15:0] ins, input logic [4:0] fl,
                             input int fw, input int mw);
    logic [3:0] op, ex;
    logic load, store, alu, br, jc, jal, taken;
    obs_t base, e;
    op = ins[15:12];
    ex = ins[7:4];
    load  = (op == 4'h4) && (ex == 4'h0);
    store = (op == 4'h4) && (ex == 4'h4);
    alu   = op inside {4'h0, 4'h1, 4'h2, 4'h5, 4'hD, 4'hF};
    taken = cond_model(ins[11:8], fl);
    br = 1'b0; jc = 1'b0; jal = 1'b0;
`ifdef CTRL_BRANCH_EN
    br  = (op == 4'hC);
    jc  = (op == 4'h4) && (ex == 4'hC);
    jal = (op == 4'h4) && (ex == 4'h8);
`endif
    exp_q.delete();
    rdy_q.delete();
    base = '0;
    base.pc_reg_sel = 1'b1;

    for (int i = 0; i <= fw; i++) begin
      e = base; e.mem_req = 1'b1; e.ir_en = (i == fw);
      exp_q.push_back(e); rdy_q.push_back(i == fw);
    end
    e = base; e.st = 3'd1;
    exp_q.push_back(e); rdy_q.push_back(1'($urandom));

    e = base; e.st = 3'd2;
    if (op inside {4'h1, 4'h2, 4'hD}) begin e.r2_im_sel = 1'b1; e.imm = 2'b10; end
    if (op == 4'h5) begin e.r2_im_sel = 1'b1; e.imm = 2'b01; end
    if (op == 4'hF) begin e.r2_im_sel = 1'b1; e.imm = 2'b00; end
    if (br) begin e.pc_reg_sel = 1'b0; e.r2_im_sel = 1'b1; e.imm = 2'b01; end
    exp_q.push_back(e); rdy_q.push_back(1'($urandom));

    if (load || store) begin
      for (int i = 0; i <= mw; i++) begin
        e = base; e.st = 3'd3; e.mem_req = 1'b1; e.mem_we = store;
        exp_q.push_back(e); rdy_q.push_back(i == mw);
      end
    end

    e = base; e.st = 3'd4; e.pc_en = 1'b1;
    e.rf_we  = alu || load || jal;
    e.wb     = load ? 2'b01 : (jal ? 2'b10 : 2'b00);
    e.pc_inc = jal || ((br || jc) && taken);
    exp_q.push_back(e); rdy_q.push_back(1'($urandom));
  endtask

  // Drives the instruction for the length of the expected trace and records outputs.
  task automatic apply(input logic [15:0] ins, input logic [4:0] fl);
    bus.instruction = ins;
    bus.flags       = fl;
    got_q.delete();
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clock);
      bus.memReady = rdy_q[i];
      #1;
      got_q.push_back(sample());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.instruction = 16'h4142;
    bus.flags = 5'b0;
    bus.memReady = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); #1;
      vectors++;
      if (bus.state !== 3'd0 || bus.memReq !== 1'b1 || bus.irEn !== 1'b0 || bus.pcEn !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold: state=%0d memReq=%b irEn=%b pcEn=%b, want 0/1/0/0",
                 bus.state, bus.memReq, bus.irEn, bus.pcEn);
      end
    end
    @(negedge clock);
    bus.memReady = 1'b0;
    reset = 1'b0;
    // STORE up to the first MEM cycle, then reset mid-cycle.
    @(negedge clock); bus.memReady = 1'b1;
    @(negedge clock); bus.memReady = 1'b0;
    @(negedge clock);
    @(negedge clock); #1;
    vectors++;
    if (bus.state !== 3'd3 || bus.memWe !== 1'b1 || bus.memReq !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_pre_mem: state=%0d memWe=%b memReq=%b, want 3/1/1",
               bus.state, bus.memWe, bus.memReq);
    end
    #2 reset = 1'b1;
    bus.memReady = 1'b1;
    #1;
    vectors++;
    if (bus.state !== 3'd0 || bus.memWe !== 1'b0 || bus.memReq !== 1'b1 || bus.irEn !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_mem: state=%0d memWe=%b memReq=%b irEn=%b, want 0/0/1/0",
               bus.state, bus.memWe, bus.memReq, bus.irEn);
    end
    @(negedge clock);
    reset = 1'b0;
    bus.memReady = 1'b0;
    build_trace(16'h5123, 5'b0, 1, 0);
    apply(16'h5123, 5'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL after_reset cyc%0d: got %b want %b", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_addi();
    build_trace(16'h5123, 5'b0, 0, 0);
    apply(16'h5123, 5'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL addi cyc%0d: got %b want %b", i, got_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (got_q[0].ir_en !== 1'b1 || got_q[2].imm !== 2'b01 || got_q[3].rf_we !== 1'b1) begin
      miscompares++;
      $display("FAIL addi_fields: irEn=%b imm=%b rfWe=%b, want 1/01/1",
               got_q[0].ir_en, got_q[2].imm, got_q[3].rf_we);
    end
    // Cycle 4 must be FETCH again; memReady low keeps it there.
    @(negedge clock);
    bus.memReady = 1'b0;
    #1;
    vectors++;
    if (bus.state !== 3'd0 || bus.memReq !== 1'b1) begin
      miscompares++;
      $display("FAIL addi_refetch: state=%0d memReq=%b, want 0/1", bus.state, bus.memReq);
    end
  endtask

  task automatic test_load_wait();
    build_trace(16'h4102, 5'b0, 0, 3);
    apply(16'h4102, 5'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL load_wait cyc%0d: got %b want %b", i, got_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (got_q[6].st !== 3'd3 || got_q[7].st !== 3'd4 || got_q[7].wb !== 2'b01) begin
      miscompares++;
      $display("FAIL load_mem_len: st6=%0d st7=%0d wb=%b, want 3/4/01",
               got_q[6].st, got_q[7].st, got_q[7].wb);
    end
  endtask

  task automatic test_store();
    build_trace(16'h4142, 5'b0, 0, 0);
    apply(16'h4142, 5'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL store cyc%0d: got %b want %b", i, got_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (got_q[3].mem_we !== 1'b1 || got_q[4].rf_we !== 1'b0 || got_q[4].pc_en !== 1'b1) begin
      miscompares++;
      $display("FAIL store_fields: memWe=%b rfWe=%b pcEn=%b, want 1/0/1",
               got_q[3].mem_we, got_q[4].rf_we, got_q[4].pc_en);
    end
  endtask

  task automatic test_branch();
    logic [15:0] ins [3] = '{16'hC005, 16'hC005, 16'h4385};
    logic [4:0]  fl  [3] = '{5'b10000, 5'b00000, 5'b00000};
`ifdef CTRL_BRANCH_EN
    logic [2:0]  want [3] = '{3'b100, 3'b000, 3'b111}; // {pcIncOrSet, rfWe, wbSel[1]}
`else
    logic [2:0]  want [3] = '{3'b000, 3'b000, 3'b000};
`endif
    for (int k = 0; k < 3; k++) begin
      build_trace(ins[k], fl[k], 0, 0);
      apply(ins[k], fl[k]);
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (got_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL branch%0d cyc%0d: got %b want %b", k, i, got_q[i], exp_q[i]);
        end
      end
      vectors++;
      if ({got_q[3].pc_inc, got_q[3].rf_we, got_q[3].wb[1]} !== want[k] || got_q[3].st !== 3'd4) begin
        miscompares++;
        $display("FAIL branch%0d_wb: pcInc/rfWe/wb1=%b st=%0d, want %b st=4",
                 k, {got_q[3].pc_inc, got_q[3].rf_we, got_q[3].wb[1]}, got_q[3].st, want[k]);
      end
    end
  endtask

  task automatic test_undefined();
    build_trace(16'h3000, 5'b11111, 0, 0);
    apply(16'h3000, 5'b11111);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL undef cyc%0d: got %b want %b", i, got_q[i], exp_q[i]);
      end
    end
    vectors++;
    if (got_q[3].st !== 3'd4 || got_q[3].rf_we !== 1'b0 || got_q[3].pc_en !== 1'b1) begin
      miscompares++;
      $display("FAIL undef_wb: st=%0d rfWe=%b pcEn=%b, want 4/0/1",
               got_q[3].st, got_q[3].rf_we, got_q[3].pc_en);
    end
  endtask

  task automatic test_random();
    logic [3:0]  ext_tab  [5] = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h2};
    logic [3:0]  cond_tab [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd14, 4'd9};
    logic [15:0] ins;
    logic [4:0]  fl;
    int fw, mw;
    for (int n = 0; n < 250; n++) begin
      ins = 16'($urandom);
      ins[15:12] = ($urandom_range(0, 2) == 0) ? 4'h4 : 4'($urandom_range(0, 15));
      ins[7:4]   = ext_tab[$urandom_range(0, 4)];
      ins[11:8]  = cond_tab[$urandom_range(0, 7)];
      fl = 5'($urandom);
      fw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      mw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      build_trace(ins, fl, fw, mw);
      apply(ins, fl);
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if (got_q[i] !== exp_q[i]) begin
          miscompares++;
          $display("FAIL random ins=%h cyc%0d: got %b want %b", ins, i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_wait();
    test_store();
    test_branch();
    test_undefined();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
